// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types and constants for the seven-segment scan controller
package display_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic {SCAN_BLANK, SCAN_SHOW} scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/sevenSegmentsDeco.sv
// rtl/sevenSegmentsDeco.sv - combinational BCD to active-low {g,f,e,d,c,b,a} decoder
module sevenSegmentsDeco
    import display_pkg::*;
(
    input  bcd_t       bcd,
    output logic [6:0] seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - multiplexed seven-segment scan controller with double-buffered BCD load
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    input  logic [4*NUM_DIGITS-1:0] load_bcd,
    output logic                    load_ready,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BW = 4 * NUM_DIGITS;

    localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    scan_state_t           state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [BW-1:0]         active_q, active_d;
    logic [BW-1:0]         pending_q, pending_d;
    logic                  pend_full_q, pend_full_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_start_q, frame_start_d;
    logic                  load_ready_q, load_ready_d;

    logic       slot_wrap;
    logic       frame_wrap;
    logic       accept;
    bcd_t       cur_bcd;
    bcd_t       dec_bcd;
    logic       upper_zero;
    logic       blanked;
    logic [6:0] dec_seg;

    assign slot_wrap  = (cnt_q == CNT_LAST);
    assign frame_wrap = slot_wrap && (idx_q == IDX_LAST);
    assign accept     = load_valid && load_ready_q;

    assign cur_bcd = active_q[4*int'(idx_q) +: 4];

    // Leading zero: this digit and every more significant digit are zero.
    always_comb begin
        upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(idx_q) && active_q[4*i +: 4] != 4'd0) begin
                upper_zero = 1'b0;
            end
        end
    end

    assign blanked = (cur_bcd > 4'd9) || (blank_lz && (idx_q != '0) && upper_zero);
    assign dec_bcd = blanked ? 4'd0 : cur_bcd;

    sevenSegmentsDeco u_deco (
        .bcd (dec_bcd),
        .seg (dec_seg)
    );

    always_comb begin
        cnt_d   = slot_wrap ? '0 : cnt_q + CW'(1);
        idx_d   = idx_q;
        state_d = state_q;
        if (slot_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
        case (state_q)
            SCAN_BLANK: if (cnt_q == BLANK_LAST) state_d = SCAN_SHOW;
            SCAN_SHOW:  if (slot_wrap)           state_d = SCAN_BLANK;
            default:                             state_d = SCAN_BLANK;
        endcase
    end

    // Commit precedes accept so a same-edge accept lands in pending, not active.
    always_comb begin
        active_d    = active_q;
        pending_d   = pending_q;
        pend_full_d = pend_full_q;
        if (frame_wrap && pend_full_q) begin
            active_d    = pending_q;
            pend_full_d = 1'b0;
        end
        if (accept) begin
            pending_d   = load_bcd;
            pend_full_d = 1'b1;
        end
        load_ready_d  = !pend_full_d;
        frame_start_d = frame_wrap;
    end

    always_comb begin
        seg_d = SEG_OFF;
        an_d  = '1;
        if (state_q == SCAN_SHOW) begin
            an_d[idx_q] = 1'b0;
            if (!blanked) begin
                seg_d = dec_seg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= SCAN_BLANK;
            cnt_q         <= '0;
            idx_q         <= '0;
            active_q      <= '0;
            pending_q     <= '0;
            pend_full_q   <= 1'b0;
            seg_q         <= SEG_OFF;
            an_q          <= '1;
            frame_start_q <= 1'b0;
            load_ready_q  <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            active_q      <= active_d;
            pending_q     <= pending_d;
            pend_full_q   <= pend_full_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
            frame_start_q <= frame_start_d;
            load_ready_q  <= load_ready_d;
        end
    end

    assign seg         = seg_q;
    assign an          = an_q;
    assign frame_start = frame_start_q;
    assign load_ready  = load_ready_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - scoreboard bench for display_scan_ctrl (4 digits, SCAN_DIV 8, BLANK_CYCLES 2)
module tb_display_scan_ctrl;

    localparam logic [6:0] OFF = 7'h7F;
    localparam logic [27:0] ZERO_LZ = {OFF, OFF, OFF, 7'h40};

    typedef struct {
        int          fid;
        logic [27:0] segs;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        load_valid;
    logic [15:0] load_bcd;
    logic        load_ready;
    logic        blank_lz;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_start;

    int   vectors;
    int   miscompares;
    int   frame_no;
    exp_t sb_q[$];

    display_scan_ctrl #(
        .NUM_DIGITS   (4),
        .SCAN_DIV     (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_valid  (load_valid),
        .load_bcd    (load_bcd),
        .load_ready  (load_ready),
        .blank_lz    (blank_lz),
        .seg         (seg),
        .an          (an),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int fid, input logic [27:0] segs);
        exp_t e;
        e.fid  = fid;
        e.segs = segs;
        sb_q.push_back(e);
    endtask

    task automatic wait_frame(output int fid);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!frame_start && n < 200);
        chk("wait_frame", {31'd0, frame_start}, 32'd1);
        fid = frame_no + 1;
    endtask

    task automatic load_word(input logic [15:0] w);
        load_valid = 1'b1;
        load_bcd   = w;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
    endtask

    // Monitor: gathers each digit's segments per frame, checks against the scoreboard at frame end.
    initial begin
        logic [6:0] rec [4];
        int         lit [4];
        int         glitches;
        exp_t       e;
        frame_no = 0;
        glitches = 0;
        for (int d = 0; d < 4; d++) begin rec[d] = OFF; lit[d] = 0; end
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                glitches = 0;
                for (int d = 0; d < 4; d++) begin rec[d] = OFF; lit[d] = 0; end
            end else begin
                if ($countones(~an) > 1) glitches++;
                if (dut.dec_bcd > 4'd9) glitches++;
                for (int d = 0; d < 4; d++) begin
                    if (!an[d]) begin
                        if (lit[d] == 0) rec[d] = seg;
                        else if (rec[d] !== seg) glitches++;
                        lit[d]++;
                    end
                end
                if (frame_start) begin
                    while (sb_q.size() > 0 && sb_q[0].fid < frame_no) begin
                        e = sb_q.pop_front();
                        miscompares++;
                        $display("FAIL frame%0d_missed: got no frame, expected %h", e.fid, e.segs);
                    end
                    if (sb_q.size() > 0 && sb_q[0].fid == frame_no) begin
                        e = sb_q.pop_front();
                        for (int d = 0; d < 4; d++) begin
                            chk($sformatf("frame%0d_digit%0d_seg", e.fid, d), {25'd0, rec[d]}, {25'd0, e.segs[7*d +: 7]});
                        end
                        chk($sformatf("frame%0d_lit_cycles", e.fid),
                            {8'(lit[3]), 8'(lit[2]), 8'(lit[1]), 8'(lit[0])}, 32'h06060606);
                        chk($sformatf("frame%0d_glitches", e.fid), glitches, 0);
                    end
                    glitches = 0;
                    for (int d = 0; d < 4; d++) begin rec[d] = OFF; lit[d] = 0; end
                    frame_no++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int fid;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        load_valid  = 1'b0;
        load_bcd    = 16'h0000;
        blank_lz    = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_seg", {25'd0, seg}, 32'h7F);
        chk("rst_load_ready", {31'd0, load_ready}, 32'd1);
        chk("rst_frame_start", {31'd0, frame_start}, 32'd0);

        push_exp(0, ZERO_LZ);
        rst_n = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!frame_start && n < 100);
        chk("first_frame_start_cycles", n, 32);
        fid = frame_no + 1;

        push_exp(fid, ZERO_LZ);
        chk("ready_idle", {31'd0, load_ready}, 32'd1);
        load_word(16'h1234);
        chk("ready_after_accept", {31'd0, load_ready}, 32'd0);
        push_exp(fid + 1, {7'h79, 7'h24, 7'h30, 7'h19});

        wait_frame(fid);
        chk("ready_after_commit", {31'd0, load_ready}, 32'd1);
        load_word(16'h0070);
        push_exp(fid + 1, {OFF, OFF, 7'h78, 7'h40});
        wait_frame(fid);

        wait_frame(fid);
        blank_lz = 1'b0;
        load_word(16'h00A5);
        push_exp(fid, {7'h40, 7'h40, 7'h78, 7'h40});
        push_exp(fid + 1, {7'h40, 7'h40, OFF, 7'h12});
        wait_frame(fid);

        wait_frame(fid);
        blank_lz = 1'b1;
        push_exp(fid, {OFF, OFF, OFF, 7'h12});
        load_valid = 1'b1;
        load_bcd   = 16'h1111;
        @(posedge clk);
        #1;
        load_bcd = 16'h2222;
        push_exp(fid + 1, {7'h79, 7'h79, 7'h79, 7'h79});
        push_exp(fid + 2, {7'h24, 7'h24, 7'h24, 7'h24});
        n = 0;
        while (!load_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("b2b_ready_at_frame_start", {31'd0, frame_start}, 32'd1);
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        chk("b2b_second_accepted", {31'd0, load_ready}, 32'd0);
        wait_frame(fid);

        wait_frame(fid);
        load_word(16'h5555);
        n = 0;
        while (an !== 4'b1011 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reach_digit2_lit", {28'd0, an}, 32'hB);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_an", {28'd0, an}, 32'hF);
        chk("midrst_seg", {25'd0, seg}, 32'h7F);
        chk("midrst_load_ready", {31'd0, load_ready}, 32'd1);
        chk("midrst_frame_start", {31'd0, frame_start}, 32'd0);
        push_exp(frame_no, ZERO_LZ);
        push_exp(frame_no + 1, ZERO_LZ);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_frame(fid);
        wait_frame(fid);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
